rv32i_instr_encoder: RTL and testbench
======================================

# rv32i_instr_encoder

Sequential RV32I instruction encoder, the inverse of the control unit's decode path. It accepts operation requests over a valid/ready handshake, where each request is an `ALUControl` op code plus rd/rs1/rs2/imm. It packs each request into a 32-bit RV32I word with a sequential PC address. The output stream drives the instruction-memory loader and the decoder self-check bench; a 2-entry output FIFO absorbs backpressure.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: address of the first emitted word after reset or restart.
- `CLK`, in, 1: single clock, rising edge.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `restart`, in, 1: synchronous. Flushes the FIFO, reloads the address to `BASE_ADDR`, clears `err_sticky`.
- `in_valid`, in, 1: request valid.
- `in_ready`, out, 1: encoder can accept a request.
- `in_op`, in, 6: operation, encoded with the shared `ALUControl` codes.
- `in_rd`, in, 5: destination register field.
- `in_rs1`, in, 5: source 1 register field.
- `in_rs2`, in, 5: source 2 register field.
- `in_imm`, in, 32: signed immediate. Byte offset for B/J; full upper value for U (bits 11:0 must be 0); shamt for shift-immediates.
- `out_valid`, out, 1: FIFO head valid.
- `out_ready`, in, 1: consumer accepts the head.
- `out_instr`, out, 32: encoded word.
- `out_addr`, out, 32: PC of `out_instr`.
- `out_err`, out, 1: head word was substituted due to an illegal request.
- `err_sticky`, out, 1: any error since reset or restart.
- `instr_count`, out, 16: requests accepted since reset or restart; wraps at 2^16.

## Operation
- Accept happens on `in_valid & in_ready`. The encoded word, address and error flag are written to the FIFO tail at that edge.
- Address counter: starts at `BASE_ADDR`, +4 per accept, wraps modulo 2^32. Errored requests still consume an address.
- Encoding follows standard RV32I fields for every op the control unit decodes: LUI, AUIPC, JAL, JALR, the 6 branches, the 5 loads, the 3 stores, the 9 I-type ALU ops, the 10 R-type ops, FENCE, ECALL, EBREAK.
  - FENCE emits 32'h0FF0000F.
  - ECALL emits 32'h00000073.
  - EBREAK emits 32'h00100073.
  - Unused register fields are forced to 0.
- Legality checks:
  - I/S immediates: −2048..2047.
  - B: −4096..4094, even.
  - J: −2^20..2^20−2, even.
  - U: `in_imm[11:0]`==0.
  - Shift-immediate: 0..31.
  - Unknown `in_op` is illegal.
- An illegal request stores 32'h00000013 (NOP) with `out_err`=1 and sets `err_sticky`.
- FIFO: 2 entries; `count` is 0..2.
  - `in_ready` = (count<2) & ~restart. It has no combinational path from `out_ready`.
  - Push and pop in the same cycle keep `count` unchanged; order is FIFO.
- Restart has priority over a simultaneous push or pop: nothing is accepted and the head is discarded.

## Timing
- Latency: a request accepted at edge N appears at the FIFO head after edge N when the FIFO was empty, so `out_valid`=1 in cycle N+1.
- Throughput: 1 word per cycle while `out_ready`=1.
- `out_*` is stable while `out_valid & ~out_ready`.
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_instr`=0, `out_addr`=`BASE_ADDR`.
  - `out_err`=0, `err_sticky`=0, `instr_count`=0.
  - Address counter = `BASE_ADDR`, FIFO empty.
- Reset asserted mid-stream clears everything immediately. Words in flight are lost.

## Structure
- Shared package `global.v` holds:
  - the `ALUControl` op-code macros and instruction-type codes, shared with the control unit;
  - the RV32I opcode/funct3/funct7 constants;
  - the NOP constant.
- Sub-module `rv32i_field_pack` is purely combinational: op + fields → {word, illegal}.
- The FIFO, address counter and counters live in the top module.

## Test plan
- ADDI rd=1 rs1=0 imm=5 after reset → 32'h00500093 at `out_addr`=`BASE_ADDR`, `out_err`=0, `instr_count`=1.
- BEQ rs1=1 rs2=2 imm=8, then SRAI rd=3 rs1=3 imm=4, then LUI rd=5 imm=32'h12345000 → 32'h00208463, 32'h4041D193, 32'h123452B7 at addresses +0, +4, +8.
- Backpressure: hold `out_ready`=0 and offer 3 requests → the first 2 are accepted, `in_ready`=0, and the 3rd is held. Release → all 3 emerge in order with consecutive addresses.
- Error: ADDI imm=2048 → 32'h00000013 with `out_err`=1 and `err_sticky`=1. The next legal request gets the next address and `out_err`=0.
- Restart with the FIFO full and `in_valid`=1 → the request is not accepted, `out_valid`=0 the next cycle, the next accepted word is at `BASE_ADDR`, and `err_sticky`=0.
- Assert `RST_N`=0 asynchronously mid-burst → all outputs show their reset values before the next clock edge.

Source files
------------

// File: rtl/rv32i_instr_encoder_pkg.sv
// Shared RV32I encoding constants: ALUControl op codes, instruction formats,
// opcode/funct fields and fixed instruction words.
package rv32i_instr_encoder_pkg;

   // ALUControl op codes shared with the control unit; 40..63 are unassigned
   localparam logic [5:0] OP_LUI    = 6'd0;
   localparam logic [5:0] OP_AUIPC  = 6'd1;
   localparam logic [5:0] OP_JAL    = 6'd2;
   localparam logic [5:0] OP_JALR   = 6'd3;
   localparam logic [5:0] OP_BEQ    = 6'd4;
   localparam logic [5:0] OP_BNE    = 6'd5;
   localparam logic [5:0] OP_BLT    = 6'd6;
   localparam logic [5:0] OP_BGE    = 6'd7;
   localparam logic [5:0] OP_BLTU   = 6'd8;
   localparam logic [5:0] OP_BGEU   = 6'd9;
   localparam logic [5:0] OP_LB     = 6'd10;
   localparam logic [5:0] OP_LH     = 6'd11;
   localparam logic [5:0] OP_LW     = 6'd12;
   localparam logic [5:0] OP_LBU    = 6'd13;
   localparam logic [5:0] OP_LHU    = 6'd14;
   localparam logic [5:0] OP_SB     = 6'd15;
   localparam logic [5:0] OP_SH     = 6'd16;
   localparam logic [5:0] OP_SW     = 6'd17;
   localparam logic [5:0] OP_ADDI   = 6'd18;
   localparam logic [5:0] OP_SLTI   = 6'd19;
   localparam logic [5:0] OP_SLTIU  = 6'd20;
   localparam logic [5:0] OP_XORI   = 6'd21;
   localparam logic [5:0] OP_ORI    = 6'd22;
   localparam logic [5:0] OP_ANDI   = 6'd23;
   localparam logic [5:0] OP_SLLI   = 6'd24;
   localparam logic [5:0] OP_SRLI   = 6'd25;
   localparam logic [5:0] OP_SRAI   = 6'd26;
   localparam logic [5:0] OP_ADD    = 6'd27;
   localparam logic [5:0] OP_SUB    = 6'd28;
   localparam logic [5:0] OP_SLL    = 6'd29;
   localparam logic [5:0] OP_SLT    = 6'd30;
   localparam logic [5:0] OP_SLTU   = 6'd31;
   localparam logic [5:0] OP_XOR    = 6'd32;
   localparam logic [5:0] OP_SRL    = 6'd33;
   localparam logic [5:0] OP_SRA    = 6'd34;
   localparam logic [5:0] OP_OR     = 6'd35;
   localparam logic [5:0] OP_AND    = 6'd36;
   localparam logic [5:0] OP_FENCE  = 6'd37;
   localparam logic [5:0] OP_ECALL  = 6'd38;
   localparam logic [5:0] OP_EBREAK = 6'd39;

   // RV32I major opcodes
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
   localparam logic [31:0] FENCE_WORD  = 32'h0FF0_000F;
   localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
   localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

   // Instruction-type codes; FmtIsh is the shift-immediate flavour of I-type
   typedef enum logic [3:0] {
      FmtBad, FmtU, FmtJ, FmtI, FmtIsh, FmtS, FmtB, FmtR, FmtFixed
   } fmt_e;

   typedef struct packed {
      fmt_e       fmt;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
   } op_info_t;

   // Decode table: op code -> format and fixed opcode/funct fields
   function automatic op_info_t op_info(input logic [5:0] op);
      op_info_t i;
      case (op)
         OP_LUI:    i = '{FmtU,     OPC_LUI,    3'b000, F7_BASE};
         OP_AUIPC:  i = '{FmtU,     OPC_AUIPC,  3'b000, F7_BASE};
         OP_JAL:    i = '{FmtJ,     OPC_JAL,    3'b000, F7_BASE};
         OP_JALR:   i = '{FmtI,     OPC_JALR,   3'b000, F7_BASE};
         OP_BEQ:    i = '{FmtB,     OPC_BRANCH, 3'b000, F7_BASE};
         OP_BNE:    i = '{FmtB,     OPC_BRANCH, 3'b001, F7_BASE};
         OP_BLT:    i = '{FmtB,     OPC_BRANCH, 3'b100, F7_BASE};
         OP_BGE:    i = '{FmtB,     OPC_BRANCH, 3'b101, F7_BASE};
         OP_BLTU:   i = '{FmtB,     OPC_BRANCH, 3'b110, F7_BASE};
         OP_BGEU:   i = '{FmtB,     OPC_BRANCH, 3'b111, F7_BASE};
         OP_LB:     i = '{FmtI,     OPC_LOAD,   3'b000, F7_BASE};
         OP_LH:     i = '{FmtI,     OPC_LOAD,   3'b001, F7_BASE};
         OP_LW:     i = '{FmtI,     OPC_LOAD,   3'b010, F7_BASE};
         OP_LBU:    i = '{FmtI,     OPC_LOAD,   3'b100, F7_BASE};
         OP_LHU:    i = '{FmtI,     OPC_LOAD,   3'b101, F7_BASE};
         OP_SB:     i = '{FmtS,     OPC_STORE,  3'b000, F7_BASE};
         OP_SH:     i = '{FmtS,     OPC_STORE,  3'b001, F7_BASE};
         OP_SW:     i = '{FmtS,     OPC_STORE,  3'b010, F7_BASE};
         OP_ADDI:   i = '{FmtI,     OPC_OPIMM,  3'b000, F7_BASE};
         OP_SLTI:   i = '{FmtI,     OPC_OPIMM,  3'b010, F7_BASE};
         OP_SLTIU:  i = '{FmtI,     OPC_OPIMM,  3'b011, F7_BASE};
         OP_XORI:   i = '{FmtI,     OPC_OPIMM,  3'b100, F7_BASE};
         OP_ORI:    i = '{FmtI,     OPC_OPIMM,  3'b110, F7_BASE};
         OP_ANDI:   i = '{FmtI,     OPC_OPIMM,  3'b111, F7_BASE};
         OP_SLLI:   i = '{FmtIsh,   OPC_OPIMM,  3'b001, F7_BASE};
         OP_SRLI:   i = '{FmtIsh,   OPC_OPIMM,  3'b101, F7_BASE};
         OP_SRAI:   i = '{FmtIsh,   OPC_OPIMM,  3'b101, F7_ALT};
         OP_ADD:    i = '{FmtR,     OPC_OP,     3'b000, F7_BASE};
         OP_SUB:    i = '{FmtR,     OPC_OP,     3'b000, F7_ALT};
         OP_SLL:    i = '{FmtR,     OPC_OP,     3'b001, F7_BASE};
         OP_SLT:    i = '{FmtR,     OPC_OP,     3'b010, F7_BASE};
         OP_SLTU:   i = '{FmtR,     OPC_OP,     3'b011, F7_BASE};
         OP_XOR:    i = '{FmtR,     OPC_OP,     3'b100, F7_BASE};
         OP_SRL:    i = '{FmtR,     OPC_OP,     3'b101, F7_BASE};
         OP_SRA:    i = '{FmtR,     OPC_OP,     3'b101, F7_ALT};
         OP_OR:     i = '{FmtR,     OPC_OP,     3'b110, F7_BASE};
         OP_AND:    i = '{FmtR,     OPC_OP,     3'b111, F7_BASE};
         OP_FENCE:  i = '{FmtFixed, 7'd0,       3'b000, F7_BASE};
         OP_ECALL:  i = '{FmtFixed, 7'd0,       3'b000, F7_BASE};
         OP_EBREAK: i = '{FmtFixed, 7'd0,       3'b000, F7_BASE};
         default:   i = '{FmtBad,   7'd0,       3'b000, F7_BASE};
      endcase
      return i;
   endfunction

endpackage

// File: rtl/rv32i_instr_encoder_field_pack.sv
// Combinational packer: op code plus register/immediate fields -> RV32I word,
// with an illegal flag that replaces the word by a NOP.
module rv32i_field_pack
   import rv32i_instr_encoder_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   op_info_t    info;
   logic [31:0] raw;
   logic        bad;
   logic        fits_i, fits_b, fits_j, fits_u, fits_sh;

   assign info = op_info(op);

   // Range checks: every bit above the field's sign bit must match it
   assign fits_i  = (&imm[31:11]) | ~(|imm[31:11]);
   assign fits_b  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
   assign fits_j  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
   assign fits_u  = ~(|imm[11:0]);
   assign fits_sh = ~(|imm[31:5]);

   // Assemble the word for the decoded format and flag out-of-range requests
   always_comb begin
      raw = NOP_WORD;
      bad = 1'b0;
      case (info.fmt)
         FmtU: begin
            raw = {imm[31:12], rd, info.opc};
            bad = ~fits_u;
         end
         FmtJ: begin
            raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, info.opc};
            bad = ~fits_j;
         end
         FmtI: begin
            raw = {imm[11:0], rs1, info.f3, rd, info.opc};
            bad = ~fits_i;
         end
         FmtIsh: begin
            raw = {info.f7, imm[4:0], rs1, info.f3, rd, info.opc};
            bad = ~fits_sh;
         end
         FmtS: begin
            raw = {imm[11:5], rs2, rs1, info.f3, imm[4:0], info.opc};
            bad = ~fits_i;
         end
         FmtB: begin
            raw = {imm[12], imm[10:5], rs2, rs1, info.f3, imm[4:1], imm[11], info.opc};
            bad = ~fits_b;
         end
         FmtR: begin
            raw = {info.f7, rs2, rs1, info.f3, rd, info.opc};
         end
         FmtFixed: begin
            case (op)
               OP_FENCE: raw = FENCE_WORD;
               OP_ECALL: raw = ECALL_WORD;
               default:  raw = EBREAK_WORD;
            endcase
         end
         default: bad = 1'b1;
      endcase
   end

   assign word    = bad ? NOP_WORD : raw;
   assign illegal = bad;

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Sequential RV32I encoder: valid/ready request in, 2-entry FIFO of
// {word, pc, err} out, with a running PC and accept counter.
module rv32i_instr_encoder
   import rv32i_instr_encoder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        restart,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  in_op,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        out_err,
   output logic        err_sticky,
   output logic [15:0] instr_count
);

   logic [31:0] pack_word;
   logic        pack_illegal;
   logic        push, pop;

   logic [1:0]  count_q, count_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [31:0] addr_q, addr_d;
   logic        err_sticky_q, err_sticky_d;
   logic [15:0] instr_count_q, instr_count_d;

   logic [31:0] fifo_instr_q [2];
   logic [31:0] fifo_addr_q  [2];
   logic        fifo_err_q   [2];

   rv32i_field_pack u_field_pack (
      .op      (in_op),
      .rd      (in_rd),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .imm     (in_imm),
      .word    (pack_word),
      .illegal (pack_illegal)
   );

   // Ready depends only on registered occupancy, never on out_ready
   assign in_ready  = (count_q != 2'd2) & ~restart;
   assign push      = in_valid & in_ready;
   assign out_valid = (count_q != 2'd0);
   assign pop       = out_valid & out_ready & ~restart;

   // Next-state for occupancy, pointers, PC and counters; restart wins
   always_comb begin
      count_d       = count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      addr_d        = addr_q;
      err_sticky_d  = err_sticky_q;
      instr_count_d = instr_count_q;
      if (restart) begin
         count_d       = 2'd0;
         wr_ptr_d      = 1'b0;
         rd_ptr_d      = 1'b0;
         addr_d        = BASE_ADDR;
         err_sticky_d  = 1'b0;
         instr_count_d = 16'd0;
      end else begin
         if (push) begin
            wr_ptr_d      = ~wr_ptr_q;
            addr_d        = addr_q + 32'd4;
            instr_count_d = instr_count_q + 16'd1;
            if (pack_illegal) begin
               err_sticky_d = 1'b1;
            end
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count_q       <= 2'd0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         addr_q        <= BASE_ADDR;
         err_sticky_q  <= 1'b0;
         instr_count_q <= 16'd0;
      end else begin
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         addr_q        <= addr_d;
         err_sticky_q  <= err_sticky_d;
         instr_count_q <= instr_count_d;
      end
   end

   // FIFO storage; reset contents define the idle output values
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < 2; i++) begin
            fifo_instr_q[i] <= 32'd0;
            fifo_addr_q[i]  <= BASE_ADDR;
            fifo_err_q[i]   <= 1'b0;
         end
      end else if (push) begin
         fifo_instr_q[wr_ptr_q] <= pack_word;
         fifo_addr_q[wr_ptr_q]  <= addr_q;
         fifo_err_q[wr_ptr_q]   <= pack_illegal;
      end
   end

   assign out_instr   = fifo_instr_q[rd_ptr_q];
   assign out_addr    = fifo_addr_q[rd_ptr_q];
   assign out_err     = fifo_err_q[rd_ptr_q] & out_valid;
   assign err_sticky  = err_sticky_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Self-checking bench for rv32i_instr_encoder: directed scenarios plus random
// traffic compared against an arithmetic reference model and a queue.
module tb_rv32i_instr_encoder;
   import rv32i_instr_encoder_pkg::*;

   localparam logic [31:0] BASE = 32'hFFFF_FFF0;

   localparam int K_BAD = 0, K_U = 1, K_J = 2, K_I = 3, K_SH = 4, K_S = 5, K_B = 6,
                  K_R = 7, K_FIX = 8;
   localparam int BR_F3 [6]  = '{0, 1, 4, 5, 6, 7};
   localparam int LD_F3 [5]  = '{0, 1, 2, 4, 5};
   localparam int AI_F3 [6]  = '{0, 2, 3, 4, 6, 7};
   localparam int R_F3  [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
   localparam int R_F7  [10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
   localparam int EDGES [16] = '{-4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095,
                                 31, 32, -1, 1048574, 1048576, -1048576, -1048578, 0};

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        restart = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_op = 6'd0;
   logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
   logic [31:0] in_imm = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr, out_addr;
   logic        out_err, err_sticky;
   logic [15:0] instr_count;

   rv32i_instr_encoder #(.BASE_ADDR(BASE)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .restart     (restart),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_rd       (in_rd),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_imm      (in_imm),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_addr    (out_addr),
      .out_err     (out_err),
      .err_sticky  (err_sticky),
      .instr_count (instr_count)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        err;
   } entry_t;

   entry_t      mq[$];
   logic [31:0] m_addr;
   logic        m_sticky;
   logic [15:0] m_cnt;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference encoder built from the RV32I field layout with plain arithmetic
   function automatic void ref_encode(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [31:0] imm,
                                      output logic [31:0] w, output logic bad);
      int s, k, idx;
      logic [31:0] opc, f3, f7, d, r1, r2;
      s   = int'(imm);
      idx = int'(op);
      d   = 32'(rd) << 7;
      r1  = 32'(rs1) << 15;
      r2  = 32'(rs2) << 20;
      k = K_BAD; opc = 0; f3 = 0; f7 = 0; w = 0; bad = 0;
      if (op == OP_LUI)                          begin k = K_U; opc = 'h37; end
      else if (op == OP_AUIPC)                   begin k = K_U; opc = 'h17; end
      else if (op == OP_JAL)                     begin k = K_J; opc = 'h6F; end
      else if (op == OP_JALR)                    begin k = K_I; opc = 'h67; end
      else if (op >= OP_BEQ && op <= OP_BGEU)    begin
         k = K_B; opc = 'h63; f3 = 32'(BR_F3[idx - 4]);
      end
      else if (op >= OP_LB && op <= OP_LHU)      begin
         k = K_I; opc = 'h03; f3 = 32'(LD_F3[idx - 10]);
      end
      else if (op >= OP_SB && op <= OP_SW)       begin k = K_S; opc = 'h23; f3 = 32'(idx - 15); end
      else if (op >= OP_ADDI && op <= OP_ANDI)   begin
         k = K_I; opc = 'h13; f3 = 32'(AI_F3[idx - 18]);
      end
      else if (op == OP_SLLI)                    begin k = K_SH; opc = 'h13; f3 = 1; end
      else if (op == OP_SRLI)                    begin k = K_SH; opc = 'h13; f3 = 5; end
      else if (op == OP_SRAI)                    begin k = K_SH; opc = 'h13; f3 = 5; f7 = 32; end
      else if (op >= OP_ADD && op <= OP_AND)     begin
         k = K_R; opc = 'h33; f3 = 32'(R_F3[idx - 27]); f7 = 32'(R_F7[idx - 27]);
      end
      else if (op == OP_FENCE)                   begin k = K_FIX; w = 32'h0FF0000F; end
      else if (op == OP_ECALL)                   begin k = K_FIX; w = 32'h00000073; end
      else if (op == OP_EBREAK)                  begin k = K_FIX; w = 32'h00100073; end
      case (k)
         K_U: begin
            bad = (imm % 4096) != 0;
            w = (imm & 32'hFFFFF000) | d | opc;
         end
         K_J: begin
            bad = s < -(1 << 20) || s > (1 << 20) - 2 || (s % 2) != 0;
            w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21) |
                (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hFF) << 12) | d | opc;
         end
         K_I: begin
            bad = s < -2048 || s > 2047;
            w = ((imm & 'hFFF) << 20) | r1 | (f3 << 12) | d | opc;
         end
         K_SH: begin
            bad = s < 0 || s > 31;
            w = (f7 << 25) | ((imm & 'h1F) << 20) | r1 | (f3 << 12) | d | opc;
         end
         K_S: begin
            bad = s < -2048 || s > 2047;
            w = (((imm >> 5) & 'h7F) << 25) | r2 | r1 | (f3 << 12) | ((imm & 'h1F) << 7) | opc;
         end
         K_B: begin
            bad = s < -4096 || s > 4094 || (s % 2) != 0;
            w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | r2 | r1 |
                (f3 << 12) | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | opc;
         end
         K_R:   w = (f7 << 25) | r2 | r1 | (f3 << 12) | d | opc;
         K_FIX: bad = 1'b0;
         default: bad = 1'b1;
      endcase
      if (bad) w = 32'h00000013;
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_addr   = BASE;
      m_sticky = 1'b0;
      m_cnt    = 16'd0;
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"},    32'(in_ready),    32'd1);
      check({tag, "_out_valid"},   32'(out_valid),   32'd0);
      check({tag, "_out_instr"},   out_instr,        32'd0);
      check({tag, "_out_addr"},    out_addr,         BASE);
      check({tag, "_out_err"},     32'(out_err),     32'd0);
      check({tag, "_err_sticky"},  32'(err_sticky),  32'd0);
      check({tag, "_instr_count"}, 32'(instr_count), 32'd0);
   endtask

   // One clock: drive at negedge, check against the model, update after the edge
   task automatic cycle(input logic v, input logic [5:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic ordy, input logic rst);
      logic [31:0] w;
      logic        bad, exp_ready, do_push, do_pop;
      entry_t      e;
      in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      out_ready = ordy; restart = rst;
      #1;
      exp_ready = (mq.size() < 2) && !rst;
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         check("out_instr", out_instr, mq[0].instr);
         check("out_addr", out_addr, mq[0].addr);
         check("out_err", 32'(out_err), 32'(mq[0].err));
      end
      check("err_sticky", 32'(err_sticky), 32'(m_sticky));
      check("instr_count", 32'(instr_count), 32'(m_cnt));
      do_push = v && exp_ready;
      do_pop  = (mq.size() > 0) && ordy;
      @(posedge CLK);
      if (rst) begin
         model_reset();
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            ref_encode(op, rd, rs1, rs2, imm, w, bad);
            e.instr = w; e.addr = m_addr; e.err = bad;
            mq.push_back(e);
            m_addr = m_addr + 32'd4;
            m_cnt  = m_cnt + 16'd1;
            if (bad) m_sticky = 1'b1;
         end
      end
      #1;
      in_valid = 1'b0; out_ready = 1'b0; restart = 1'b0;
      @(negedge CLK);
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd0, ordy, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int          sel;
      logic [31:0] imm;
      model_reset();
      repeat (2) @(negedge CLK);
      #1;
      check_reset_values("rst_hold");
      RST_N = 1'b1;
      @(negedge CLK);
      check_reset_values("rst_rel");

      // ADDI after reset
      cycle(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b0);
      check("addi_word", out_instr, 32'h00500093);
      check("addi_addr", out_addr, BASE);
      check("addi_err", 32'(out_err), 32'd0);
      check("addi_count", 32'(instr_count), 32'd1);

      // BEQ, SRAI, LUI streamed with out_ready high
      cycle(1'b1, OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 1'b0);
      check("beq_word", out_instr, 32'h00208463);
      check("beq_addr", out_addr, BASE + 32'd4);
      cycle(1'b1, OP_SRAI, 5'd3, 5'd3, 5'd0, 32'd4, 1'b1, 1'b0);
      check("srai_word", out_instr, 32'h4041D193);
      check("srai_addr", out_addr, BASE + 32'd8);
      cycle(1'b1, OP_LUI, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 1'b0);
      check("lui_word", out_instr, 32'h123452B7);
      check("lui_addr", out_addr, BASE + 32'd12);
      idle(1'b1);

      // Backpressure: third request held until space frees
      cycle(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0);
      cycle(1'b1, OP_SUB, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0, 1'b0);
      check("bp_full_ready", 32'(in_ready), 32'd0);
      cycle(1'b1, OP_XOR, 5'd7, 5'd8, 5'd9, 32'd0, 1'b0, 1'b0);
      cycle(1'b1, OP_XOR, 5'd7, 5'd8, 5'd9, 32'd0, 1'b1, 1'b0);
      cycle(1'b1, OP_XOR, 5'd7, 5'd8, 5'd9, 32'd0, 1'b1, 1'b0);
      repeat (3) idle(1'b1);

      // Illegal immediate becomes a flagged NOP; next legal word is clean
      cycle(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b0);
      check("err_word", out_instr, 32'h00000013);
      check("err_flag", 32'(out_err), 32'd1);
      check("err_sticky_set", 32'(err_sticky), 32'd1);
      cycle(1'b1, OP_ADDI, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
      check("post_err_flag", 32'(out_err), 32'd0);
      idle(1'b1);

      // Restart with a full FIFO and a pending request
      cycle(1'b1, OP_OR, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 1'b0);
      cycle(1'b1, OP_AND, 5'd2, 5'd2, 5'd2, 32'd0, 1'b0, 1'b0);
      cycle(1'b1, OP_SLT, 5'd3, 5'd3, 5'd3, 32'd0, 1'b1, 1'b1);
      check("rs_out_valid", 32'(out_valid), 32'd0);
      check("rs_sticky", 32'(err_sticky), 32'd0);
      cycle(1'b1, OP_ORI, 5'd4, 5'd4, 5'd0, 32'd7, 1'b0, 1'b0);
      check("rs_addr", out_addr, BASE);
      cycle(1'b1, OP_ECALL, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);

      // Asynchronous reset between edges with words in flight
      #1 RST_N = 1'b0;
      #1 check_reset_values("async_rst");
      #1 RST_N = 1'b1;
      model_reset();
      @(negedge CLK);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         sel = int'($urandom_range(0, 7));
         case (sel)
            0, 1:    imm = 32'(EDGES[$urandom_range(0, 15)]);
            2:       imm = $urandom_range(0, 31);
            3:       imm = 32'(int'($urandom_range(0, 8191)) - 4096);
            4:       imm = $urandom & 32'hFFFFF000;
            5:       imm = 32'(int'($urandom_range(0, 4194303)) - 2097152);
            default: imm = $urandom;
         endcase
         cycle($urandom_range(0, 3) != 0, 6'($urandom_range(0, 47)), 5'($urandom),
               5'($urandom), 5'($urandom), imm, $urandom_range(0, 3) != 0,
               $urandom_range(0, 63) == 0);
      end
      repeat (3) idle(1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
